// File: rtl/uart_rx_sampler_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler_if
// Description : Bundles the serial input line and the sampler's downstream
//               control/status outputs. The sampler uses the master modport.
//               A shift register or frame consumer uses the slave modport.
//   i_rx        - serial line, idle high
//   o_sclr      - clear pulse at frame start (to shift register i_sclr)
//   o_en        - shift-enable pulse per data bit (to shift register i_en)
//   o_bit       - sampled data bit, valid with o_en (to shift register i_bit)
//   o_done      - frame completed, stop bit high
//   o_frame_err - stop bit sampled low
//   o_busy      - receiver is not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_sampler_if;
    logic i_rx;
    logic o_sclr;
    logic o_en;
    logic o_bit;
    logic o_done;
    logic o_frame_err;
    logic o_busy;

    modport master (
        input  i_rx,
        output o_sclr, o_en, o_bit, o_done, o_frame_err, o_busy
    );

    modport slave (
        output i_rx,
        input  o_sclr, o_en, o_bit, o_done, o_frame_err, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler
// Description : UART receive front-end. It synchronises the serial line and
//               detects the start bit. Each data bit is sampled at mid-bit and
//               drives the clear, enable and bit inputs of a downstream
//               enable-gated shift register. The block also reports frame
//               completion or a framing error.
// Ports       : clk     - clock, rising edge
//               i_arst  - asynchronous active-high reset
//               bus     - uart_rx_sampler_if.master (i_rx in, pulses/busy out)
// Parameters  : CLKS_PER_BIT - clocks per serial bit (even, >= 4)
//               DATA_BITS    - data bits per frame (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  wire               clk,
    input  wire               i_arst,
    uart_rx_sampler_if.master bus
);

    localparam int c_CW = $clog2(CLKS_PER_BIT);
    localparam int c_IW = $clog2(DATA_BITS + 1);

    // The start bit is checked half a bit in. After that, every check is one
    // full bit later, so each data and stop sample lands near mid-bit.
    localparam logic [c_CW-1:0] c_CNT_HALF = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic [c_IW-1:0] r_idx;
    logic [c_IW-1:0] w_idx_nxt;

    logic r_sync1;
    logic r_rx_s;

    logic r_sclr, w_sclr_nxt;
    logic r_en,   w_en_nxt;
    logic r_bit,  w_bit_nxt;
    logic r_done, w_done_nxt;
    logic r_err,  w_err_nxt;
    logic r_busy;

    // Two-flop synchroniser. It resets to the idle (high) level so that
    // releasing reset cannot look like a start bit.
    always_ff @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= bus.i_rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sclr  <= 1'b0;
            r_en    <= 1'b0;
            r_bit   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_sclr  <= w_sclr_nxt;
            r_en    <= w_en_nxt;
            r_bit   <= w_bit_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            // Busy is taken from the next state, so it rises with o_sclr and
            // falls in the same cycle that the FSM is back in IDLE.
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_sclr_nxt  = 1'b0;
        w_en_nxt    = 1'b0;
        w_bit_nxt   = r_bit;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_idx_nxt   = '0;
                    w_sclr_nxt  = 1'b1;
                end
            end

            S_START: begin
                if (r_cnt == c_CNT_HALF) begin
                    w_cnt_nxt = '0;
                    // A line that is high again at mid start bit was a glitch.
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (r_cnt == c_CNT_FULL) begin
                    w_cnt_nxt = '0;
                    w_en_nxt  = 1'b1;
                    w_bit_nxt = r_rx_s;
                    w_idx_nxt = r_idx + 1'b1;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (r_cnt == c_CNT_FULL) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end

            S_WAIT_IDLE: begin
                // Hold here while the line is low (break or stuck line), so a
                // low line cannot start a new frame.
                w_cnt_nxt = '0;
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.o_sclr      = r_sclr;
    assign bus.o_en        = r_en;
    assign bus.o_bit       = r_bit;
    assign bus.o_done      = r_done;
    assign bus.o_frame_err = r_err;
    assign bus.o_busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Serial receive front-end that sits directly upstream of the enable-gated bit shift register (`bshift_reg_en`). It synchronises the asynchronous `i_rx` line and detects the start bit. It samples each data bit at mid-bit and drives the shift register's clear, enable and bit inputs. It also reports frame completion or stop-bit framing errors to the frame consumer.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit.
  - Must be ≥ 4.
  - Must be even.
- `DATA_BITS`, default 8: data bits per frame. Must be ≥ 1.

Ports:
- `clk` in 1: single clock. All logic is on its rising edge.
- `i_arst` in 1: reset. Asynchronous, active-high.
- `i_rx` in 1: serial line.
  - Idle high, LSB-first.
  - Frame is 1 start bit (0), `DATA_BITS` data bits, 1 stop bit (1).
- `o_sclr` out 1: one-cycle pulse at frame start. Drives downstream `i_sclr`.
- `o_en` out 1: one-cycle pulse per sampled data bit. Drives downstream `i_en`.
- `o_bit` out 1: sampled data bit. Valid when `o_en`=1. Drives downstream `i_bit`.
- `o_done` out 1: one-cycle pulse when the stop bit is sampled high.
- `o_frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `o_busy` out 1: high whenever the FSM is not in `IDLE`.

## Operation
- Synchroniser: 2 flops on `i_rx`. Both reset to 1. `rx_s` is the output of the second flop.
- Cycle counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide. It clears to 0 on every state entry and increments each cycle within a state.
- Bit index `idx` is `$clog2(DATA_BITS+1)` bits wide.
- FSM states: `IDLE`, `START`, `DATA`, `STOP`, `WAIT_IDLE`.

State transitions:
- `IDLE`:
  - `rx_s`=0 → `START`, `cnt`=0, `idx`=0, `o_sclr` pulse.
  - Otherwise stay.
- `START`: at `cnt`=`CLKS_PER_BIT/2`−1, sample `rx_s`.
  - 0 → `DATA`.
  - 1 → `IDLE` (false start). No further pulses.
- `DATA`: at `cnt`=`CLKS_PER_BIT`−1, sample `rx_s`.
  - `o_en` pulse with `o_bit`=sample, then `idx`++.
  - When `idx` reaches `DATA_BITS` → `STOP`.
  - Otherwise re-enter `DATA` with `cnt`=0.
- `STOP`: at `cnt`=`CLKS_PER_BIT`−1, sample `rx_s`.
  - 1 → `o_done` pulse, go to `IDLE`.
  - 0 → `o_frame_err` pulse, go to `WAIT_IDLE`.
- `WAIT_IDLE`: stay until `rx_s`=1, then → `IDLE`. This prevents a stuck-low line from retriggering frames.

Bit ordering and output rules:
- The downstream register shifts each `o_bit` into its LSB.
- The first data bit received (the UART LSB) therefore ends at the downstream MSB. Bit reversal is the frame consumer's job.
- `o_done` and `o_frame_err` are never high together.
- `o_en` never coincides with `o_sclr`, `o_done` or `o_frame_err`.

## Timing
- Reset values:
  - `o_sclr`, `o_en`, `o_bit`, `o_done`, `o_frame_err`, `o_busy` are all 0.
  - State `IDLE`, `cnt`=0, `idx`=0, synchroniser flops 1.
- All outputs are registered. Each pulse is high for exactly 1 cycle, in the cycle after the sampling edge.
- `i_rx` falling edge to `o_sclr`: 3 cycles (2 synchroniser + 1 registered).
- Spacing between consecutive `o_en` pulses: exactly `CLKS_PER_BIT` cycles.
- `o_en` #1 follows `o_sclr` by `CLKS_PER_BIT/2` + `CLKS_PER_BIT` cycles.
- `o_done` / `o_frame_err` follows the last `o_en` by `CLKS_PER_BIT` cycles.
- `o_busy`: rises with `o_sclr`. Falls in the cycle the FSM enters `IDLE`.
- Back-to-back frames: a start bit immediately after the stop sample is detected from `IDLE`. No dead cycle is required beyond the `STOP`→`IDLE` transition.
- Reset mid-frame: all state and outputs return to reset values immediately. No pulse is emitted during or on release of reset. A partial frame is discarded, and the downstream register is cleared by the next `o_sclr`.
- `i_rx` changes between samples are ignored. Only the single mid-bit sample counts; there is no majority vote.

## Test plan
Bench parameters: `DATA_BITS`=4, `CLKS_PER_BIT`=8, `bshift_reg_en`#(4) attached.

1. Good frame with data 1,0,1,1 (LSB first) and stop 1:
   - One `o_sclr` pulse.
   - 4 `o_en` pulses, 8 cycles apart, with `o_bit`=1,0,1,1.
   - Shift register reads 4'b1011.
   - `o_done` 8 cycles after the last `o_en`.
   - `o_busy` falls with `o_done`.
2. `i_rx` low for 2 cycles only:
   - `o_sclr` pulse.
   - START sample reads 1, FSM returns to `IDLE`.
   - No `o_en`, `o_done` or `o_frame_err`.
   - `o_busy` high ~4 cycles.
3. Stop bit 0 with `i_rx` held low for 20 more cycles:
   - `o_frame_err` pulse, no `o_done`.
   - `o_busy` stays 1 until `i_rx` returns high, plus the synchroniser delay.
   - No new `o_sclr` while low.
4. Two frames back-to-back, data 0,0,0,1 then 1,1,0,0:
   - Two `o_done` pulses, 48 cycles apart.
   - Shift register reads 4'b0001 then 4'b1100.
5. `i_arst` asserted after the 2nd `o_en` and released 3 cycles later with the line idle:
   - All outputs 0 immediately.
   - No `o_done` or `o_en` afterwards.
   - Next good frame is received correctly.
